seg_display_arbiter: RTL

Shares the board's eight-digit multiplexed seven-segment display between `NREQ` independent clients. Each client supplies a full 64-bit frame of raw segment patterns. The block grants the display round-robin, switching only at scan-frame boundaries with a minimum hold time. It also runs the digit scan with PWM brightness and drives the anode and segment pins directly from the board top.

---
 rtl/seg_disp_pkg.sv | 30 +++
 rtl/seg_display_arbiter_scan.sv | 65 ++++++
 rtl/seg_display_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seg_disp_pkg.sv
// Shared constants, arbiter state type and round-robin helper for the
// multiplexed seven-segment display arbiter.
package seg_disp_pkg;

    localparam int         NDIG      = 8;
    localparam int         MAX_REQ   = 4;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // First requester strictly after ptr, wrapping over nreq clients; ptr itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr,
                                           input int unsigned nreq);
        logic       found;
        logic [1:0] idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = 2'((32'(ptr) + i) % nreq);
            if (i <= nreq && !found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/seg_display_arbiter_scan.sv
// Digit scan timing: slot/digit counters, frame boundary detection and the
// registered PWM-gated anode/segment drivers.
module seg_scan
    import seg_disp_pkg::*;
#(
    parameter int DIV_W = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_active,
    input  logic [2:0]  i_bright,
    input  logic [63:0] i_fbuf,
    output logic        o_boundary,
    output logic        o_frame_done,
    output logic [7:0]  o_an,
    output logic [7:0]  o_seg
);

    logic [DIV_W-1:0] r_scnt;
    logic [2:0]       r_dig;
    logic             r_frame_done;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;
    logic             w_slot_end;
    logic             w_lit;

    assign w_slot_end = &r_scnt;
    assign o_boundary = w_slot_end && (r_dig == 3'(NDIG - 1));
    // Top three slot-counter bits give eight PWM phases per digit slot.
    assign w_lit      = i_active && (r_scnt[DIV_W-1 -: 3] <= i_bright);

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scnt <= '0;
            r_dig  <= '0;
        end else if (i_clear) begin
            r_scnt <= '0;
            r_dig  <= '0;
        end else begin
            r_scnt <= r_scnt + 1'b1;
            if (w_slot_end) begin
                r_dig <= r_dig + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_an         <= SEG_BLANK;
            r_seg        <= SEG_BLANK;
        end else begin
            r_frame_done <= o_boundary;
            r_an         <= w_lit ? ~(8'b1 << r_dig) : SEG_BLANK;
            r_seg        <= w_lit ? i_fbuf[{r_dig, 3'b000} +: 8] : SEG_BLANK;
        end
    end

    assign o_frame_done = r_frame_done;
    assign o_an         = r_an;
    assign o_seg        = r_seg;

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the eight-digit display: grants at frame boundaries with a
// minimum hold, snapshots the owner's frame into fbuf, and drives the scan.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int DIV_W       = 11,
    parameter int HOLD_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*64-1:0] frame,
    input  logic [2:0]         bright,
    output logic [NREQ-1:0]    gnt,
    output logic               frame_done,
    output logic [7:0]         AN,
    output logic [7:0]         SEG
);

    localparam int              HCNT_W   = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(HOLD_FRAMES - 1);

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [HCNT_W-1:0] r_hcnt;
    logic [63:0]       r_fbuf;
    logic [NREQ-1:0]   r_gnt;

    logic [3:0]        w_req4;
    logic [3:0]        w_others;
    logic [63:0]       w_frames [MAX_REQ];
    logic              w_own_req;
    logic              w_any_other;
    logic              w_hold;
    logic              w_start;
    logic              w_boundary;
    logic [1:0]        w_pick_idle;
    logic [1:0]        w_pick_next;

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v[NREQ-1:0];
    endfunction

    // Pad to four clients so a 2-bit index is always in range.
    for (genvar g = 0; g < MAX_REQ; g++) begin : g_frames
        if (g < NREQ) begin : g_live
            assign w_frames[g] = frame[64*g +: 64];
        end else begin : g_pad
            assign w_frames[g] = '1;
        end
    end

    assign w_req4      = 4'(req);
    assign w_own_req   = w_req4[r_ptr];
    assign w_others    = w_req4 & ~(4'b0001 << r_ptr);
    assign w_any_other = |w_others;
    assign w_hold      = (r_hcnt < HOLD_MAX);
    assign w_start     = (r_state == IDLE) && (|req);
    assign w_pick_idle = rr_pick(w_req4, r_ptr, NREQ);
    assign w_pick_next = rr_pick(w_others, r_ptr, NREQ);

    // NOTE: fbuf is a plain 64-bit register, so it is reset to blank rather than left unknown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 2'(NREQ - 1);
            r_hcnt  <= '0;
            r_fbuf  <= '1;
            r_gnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= OWNED;
                        r_ptr   <= w_pick_idle;
                        r_gnt   <= onehot(w_pick_idle);
                        r_fbuf  <= w_frames[w_pick_idle];
                        r_hcnt  <= '0;
                    end
                end
                OWNED: begin
                    if (w_boundary) begin
                        if (w_own_req && w_hold && w_any_other) begin
                            r_hcnt <= r_hcnt + 1'b1;
                            r_fbuf <= w_frames[r_ptr];
                        end else if (w_any_other) begin
                            r_ptr  <= w_pick_next;
                            r_gnt  <= onehot(w_pick_next);
                            r_fbuf <= w_frames[w_pick_next];
                            r_hcnt <= '0;
                        end else if (w_own_req) begin
                            r_fbuf <= w_frames[r_ptr];
                            if (w_hold) begin
                                r_hcnt <= r_hcnt + 1'b1;
                            end
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt = r_gnt;

    seg_scan #(
        .DIV_W (DIV_W)
    ) u_scan (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_start),
        .i_active     (r_state == OWNED),
        .i_bright     (bright),
        .i_fbuf       (r_fbuf),
        .o_boundary   (w_boundary),
        .o_frame_done (frame_done),
        .o_an         (AN),
        .o_seg        (SEG)
    );

endmodule
